// File: rtl/axis_video_pattern_src_pkg.sv
// Shared types and constants for the AXI4-Stream video pattern source.
package video_axis_pkg;

    localparam int TDATA_W = 32;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_e;

    typedef enum logic [1:0] {
        BARS  = 2'd0,
        GRAD  = 2'd1,
        CHECK = 2'd2,
        COUNT = 2'd3
    } pattern_e;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = BAR_WHITE;
            3'd1:    bar_color = BAR_YELLOW;
            3'd2:    bar_color = BAR_CYAN;
            3'd3:    bar_color = BAR_GREEN;
            3'd4:    bar_color = BAR_MAGENTA;
            3'd5:    bar_color = BAR_RED;
            3'd6:    bar_color = BAR_BLUE;
            default: bar_color = BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/axis_video_pattern_src_if.sv
// AXI4-Stream video beat bundle: {8'h00, R, G, B} data, SOF on tuser, EOL on tlast.
interface axis_video_if;
    logic [video_axis_pkg::TDATA_W-1:0] tdata;
    logic                               tvalid;
    logic                               tready;
    logic                               tlast;
    logic                               tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_video_pattern_src_pixel.sv
// Combinational pixel colour generator for the four test patterns.
module axis_pattern_pixel
    import video_axis_pkg::*;
(
    input  pattern_e    pattern,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  bar_idx,
    input  logic [23:0] pix_cnt,
    input  logic [7:0]  frame_idx,
    output logic [23:0] rgb
);

    always_comb begin
        rgb = '0;
        case (pattern)
            BARS:  rgb = bar_color(bar_idx);
            GRAD: begin
                rgb[R_LSB +: 8] = x;
                rgb[G_LSB +: 8] = y;
                rgb[B_LSB +: 8] = frame_idx;
            end
            CHECK: rgb = (x[4] ^ y[4]) ? BAR_BLACK : BAR_WHITE;
            default: rgb = pix_cnt;
        endcase
    end

endmodule

// File: rtl/axis_video_pattern_src.sv
// Free-running AXI4-Stream RGB frame source with run control and backpressure support.
module axis_video_pattern_src
    import video_axis_pkg::*;
#(
    parameter int FRAME_W    = 640,
    parameter int FRAME_H    = 480,
    parameter int GAP_CYCLES = 20,
    parameter int CNT_W      = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_frames,
    input  logic [1:0]       pattern_sel,
    axis_video_if.master     m_axis,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int X_W   = ($clog2(FRAME_W) > 8) ? $clog2(FRAME_W) : 8;
    localparam int Y_W   = ($clog2(FRAME_H) > 8) ? $clog2(FRAME_H) : 8;
    localparam int BAR_W = FRAME_W / 8;
    localparam int RUN_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);

    localparam logic [X_W-1:0]   X_LAST   = X_W'(FRAME_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(FRAME_H - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(BAR_W - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [2:0]         bar_q, bar_d;
    logic [23:0]        cnt_q, cnt_d;
    pattern_e           pat_q, pat_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic               stop_pend_q, stop_pend_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               tvalid_q, tvalid_d;
    logic [TDATA_W-1:0] tdata_q, tdata_d;
    logic               tlast_q, tlast_d;
    logic               tuser_q, tuser_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept, last_x, last_y, load_sof, load_next;
    logic [CNT_W-1:0]   sent_inc;
    logic [23:0]        rgb;

    assign accept   = tvalid_q & m_axis.tready;
    assign last_x   = (x_q == X_LAST);
    assign last_y   = (y_q == Y_LAST);
    assign sent_inc = sent_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        sent_d      = sent_q;
        stop_pend_d = stop_pend_q;
        gap_d       = gap_q;
        tvalid_d    = tvalid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load_sof    = 1'b0;
        load_next   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d       = num_frames;
                    sent_d      = '0;
                    stop_pend_d = 1'b0;
                    busy_d      = 1'b1;
                    tvalid_d    = 1'b1;
                    load_sof    = 1'b1;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE: begin
                if (stop) stop_pend_d = 1'b1;
                if (accept) begin
                    if (last_x && last_y) begin
                        done_d = 1'b1;
                        sent_d = sent_inc;
                        // A stop landing on the final beat still ends the run here.
                        if (((num_q != '0) && (sent_inc == num_q)) || stop_pend_q || stop) begin
                            state_d  = IDLE;
                            tvalid_d = 1'b0;
                            busy_d   = 1'b0;
                        end else if (GAP_CYCLES > 0) begin
                            state_d  = GAP;
                            tvalid_d = 1'b0;
                            gap_d    = GAP_LOAD;
                        end else begin
                            load_sof = 1'b1;
                        end
                    end else begin
                        load_next = 1'b1;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (gap_q == '0) begin
                    state_d  = ACTIVE;
                    tvalid_d = 1'b1;
                    load_sof = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Coordinates of the beat being formed; bar index advances off a run counter.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        run_d = run_q;
        bar_d = bar_q;
        cnt_d = cnt_q;
        pat_d = pat_q;
        if (load_sof) begin
            x_d   = '0;
            y_d   = '0;
            run_d = '0;
            bar_d = '0;
            cnt_d = '0;
            pat_d = pattern_e'(pattern_sel);
        end else if (load_next) begin
            cnt_d = cnt_q + 24'd1;
            if (last_x) begin
                x_d   = '0;
                y_d   = y_q + Y_W'(1);
                run_d = '0;
                bar_d = '0;
            end else begin
                x_d = x_q + X_W'(1);
                if (run_q == RUN_LAST) begin
                    run_d = '0;
                    bar_d = bar_q + 3'd1;
                end else begin
                    run_d = run_q + RUN_W'(1);
                end
            end
        end
    end

    axis_pattern_pixel u_pixel (
        .pattern   (pat_d),
        .x         (x_d[7:0]),
        .y         (y_d[7:0]),
        .bar_idx   (bar_d),
        .pix_cnt   (cnt_d),
        .frame_idx (sent_d[7:0]),
        .rgb       (rgb)
    );

    always_comb begin
        tdata_d = tdata_q;
        tuser_d = tuser_q;
        tlast_d = tlast_q;
        if (load_sof || load_next) begin
            tdata_d = {8'h00, rgb};
            tuser_d = load_sof;
            tlast_d = (x_d == X_LAST);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            run_q       <= '0;
            bar_q       <= '0;
            cnt_q       <= '0;
            pat_q       <= BARS;
            num_q       <= '0;
            sent_q      <= '0;
            stop_pend_q <= 1'b0;
            gap_q       <= '0;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            run_q       <= run_d;
            bar_q       <= bar_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            num_q       <= num_d;
            sent_q      <= sent_d;
            stop_pend_q <= stop_pend_d;
            gap_q       <= gap_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = tuser_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign frames_sent   = sent_q;

endmodule

// File: tb/tb_axis_video_pattern_src.sv
// Scoreboard bench for axis_video_pattern_src: a frame-level model queues beats, a monitor checks them.
module tb_axis_video_pattern_src;

    localparam int FRAME_W    = 32;
    localparam int FRAME_H    = 20;
    localparam int GAP_CYCLES = 3;
    localparam int CNT_W      = 16;
    localparam int FR         = FRAME_W * FRAME_H;

    localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [CNT_W-1:0] num_frames = '0;
    logic [1:0]       pattern_sel = '0;
    logic             busy, frame_done;
    logic [CNT_W-1:0] frames_sent;

    axis_video_if m_axis ();

    axis_video_pattern_src #(
        .FRAME_W    (FRAME_W),
        .FRAME_H    (FRAME_H),
        .GAP_CYCLES (GAP_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start),
        .stop        (stop),
        .num_frames  (num_frames),
        .pattern_sel (pattern_sel),
        .m_axis      (m_axis),
        .busy        (busy),
        .frame_done  (frame_done),
        .frames_sent (frames_sent)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;
    logic [34:0] exp_q [$];   // {eof, tuser, tlast, tdata}
    int beats_acc = 0;
    int fd_cnt = 0;
    int ready_mode = 0;       // 0: always ready, 1: random, 2: held low

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [23:0] model_pix(input int pat, input int x, input int y, input int f);
        case (pat)
            0:       return BAR_TAB[x / (FRAME_W / 8)];
            1:       return {8'(x), 8'(y), 8'(f)};
            2:       return ((((x / 16) + (y / 16)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            default: return 24'((y * FRAME_W + x) % (1 << 24));
        endcase
    endfunction

    task automatic push_frames(input int pat, input int n);
        for (int f = 0; f < n; f++)
            for (int y = 0; y < FRAME_H; y++)
                for (int x = 0; x < FRAME_W; x++) begin
                    logic [34:0] e;
                    e = {(x == FRAME_W - 1 && y == FRAME_H - 1), (x == 0 && y == 0),
                         (x == FRAME_W - 1), 8'h00, model_pix(pat, x, y, f)};
                    exp_q.push_back(e);
                end
    endtask

    always @(posedge aclk) begin
        #1;
        case (ready_mode)
            0:       m_axis.tready = 1'b1;
            1:       m_axis.tready = 1'($urandom_range(0, 1));
            default: m_axis.tready = 1'b0;
        endcase
    end

    // Monitor: acceptance is decided at the next posedge, so sample on the falling edge.
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_rstn = 1'b0;
    logic [33:0] prev_beat = '0;
    int          gap_cnt = 0;
    bit          measuring = 1'b0, busy_dropped = 1'b0;

    always @(negedge aclk) begin
        logic [34:0] e;
        logic [33:0] beat;
        beat = {m_axis.tuser, m_axis.tlast, m_axis.tdata};
        if (prev_rstn && prev_v && !prev_r) begin
            check("hold_tvalid", m_axis.tvalid, 1);
            check("hold_beat", beat, prev_beat);
        end
        if (measuring) begin
            if (!busy || !aresetn) busy_dropped = 1'b1;
            if (m_axis.tvalid) begin
                if (!busy_dropped) check("gap_len", gap_cnt, GAP_CYCLES);
                measuring = 1'b0;
            end else begin
                gap_cnt++;
            end
        end
        if (aresetn && m_axis.tvalid && m_axis.tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got 0x%0h, expected no beat", beat);
            end else begin
                e = exp_q.pop_front();
                check("beat", beat, e[33:0]);
                beats_acc++;
                if (e[34]) begin
                    measuring    = 1'b1;
                    gap_cnt      = 0;
                    busy_dropped = 1'b0;
                end
            end
        end
        if (frame_done) fd_cnt++;
        prev_v    = m_axis.tvalid;
        prev_r    = m_axis.tready;
        prev_beat = beat;
        prev_rstn = aresetn;
    end

    task automatic run(input string tag, input int pat, input int nf_in, input int n_exp,
                       input int stop_frame, input bit gap_stop, input bit start_busy,
                       input bit scramble);
        int fd0, b0, t, scr_t;
        bit stopped, sb_done;
        stopped = 0;
        sb_done = 0;
        scr_t   = 0;
        push_frames(pat, n_exp);
        fd0 = fd_cnt;
        b0  = beats_acc;
        num_frames  = CNT_W'(nf_in);
        pattern_sel = 2'(pat);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_first_tvalid"}, m_axis.tvalid, 1);
        check({tag, "_first_tuser"}, m_axis.tuser, 1);
        check({tag, "_busy_set"}, busy, 1);
        check({tag, "_sent_clr"}, frames_sent, 0);
        t = 0;
        while (busy && t < 20000) begin
            if (stop_frame >= 0 && !stopped && (beats_acc - b0) >= stop_frame * FR + FR / 2) begin
                stop = 1'b1;
                stopped = 1;
            end else if (gap_stop && !stopped && frame_done) begin
                stop = 1'b1;
                stopped = 1;
            end
            if (start_busy && !sb_done && (beats_acc - b0) >= 100) begin
                start = 1'b1;
                num_frames = CNT_W'(1);
                sb_done = 1;
            end
            if (scramble && scr_t < 10 && (beats_acc - b0) >= FR + 50) begin
                pattern_sel = 2'(pat + 1 + (scr_t % 3));
                scr_t++;
            end else if (scramble) begin
                pattern_sel = 2'(pat);
            end
            tick();
            stop  = 1'b0;
            start = 1'b0;
            t++;
        end
        if (t >= 20000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still %0d after %0d cycles, expected 0", tag, busy, t);
        end
        @(negedge aclk);
        #1;
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_frames_sent"}, frames_sent, n_exp);
        check({tag, "_frame_done_pulses"}, fd_cnt - fd0, n_exp);
        check({tag, "_tvalid_idle"}, m_axis.tvalid, 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, m_axis.tvalid, 0);
        check({tag, "_tlast"}, m_axis.tlast, 0);
        check({tag, "_tuser"}, m_axis.tuser, 0);
        check({tag, "_tdata"}, m_axis.tdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frames_sent"}, frames_sent, 0);
    endtask

    initial begin
        int b0, t;
        m_axis.tready = 1'b1;
        aresetn = 1'b0;
        repeat (3) tick();
        check_reset_outputs("por");
        aresetn = 1'b1;
        tick();

        ready_mode = 0;
        run("cnt_ready", 3, 2, 2, -1, 0, 0, 0);
        ready_mode = 1;
        run("cnt_bp", 3, 2, 2, -1, 0, 1, 0);
        ready_mode = 0;
        run("bars", 0, 1, 1, -1, 0, 0, 0);
        ready_mode = 1;
        run("checker_bp", 2, 1, 1, -1, 0, 0, 0);
        ready_mode = 0;
        run("grad_cont_stop", 1, 0, 4, 3, 0, 0, 1);
        run("stop_in_gap", 1, 0, 1, -1, 1, 0, 0);
        ready_mode = 1;
        run("rand_pat", int'($urandom_range(0, 3)), 3, 3, -1, 0, 0, 0);

        // Reset while a beat is stalled mid-frame.
        ready_mode = 1;
        push_frames(2, 1);
        b0 = beats_acc;
        num_frames  = CNT_W'(1);
        pattern_sel = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while ((beats_acc - b0) < 10 && t < 2000) begin
            tick();
            t++;
        end
        ready_mode = 2;
        tick();
        tick();
        check("rst_pre_tvalid", m_axis.tvalid, 1);
        aresetn = 1'b0;
        tick();
        check_reset_outputs("midrst");
        exp_q.delete();
        aresetn = 1'b1;
        ready_mode = 0;
        repeat (3) tick();
        check("post_rst_idle_tvalid", m_axis.tvalid, 0);
        run("after_rst", 0, 1, 1, -1, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_video_pattern_src.md
Name: axis_video_pattern_src

Overview:
Synthesizable AXI4-Stream video source. It generates RGB frames with SOF on tuser and EOL on tlast, in the same beat format that top_axis_chain consumes.
Placed in front of the processing chain, it feeds frames without file I/O for on-chip bring-up and long-run soak tests.
It honours backpressure fully: a presented beat is held unchanged until it is accepted.

Parameters:
FRAME_W, 640, pixels per line (multiple of 8, >= 8)
FRAME_H, 480, lines per frame (>= 1)
GAP_CYCLES, 20, idle cycles between frames (0 = back-to-back)
CNT_W, 16, width of the frame-count fields

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  synchronous reset, active low
start  in  1  one-cycle pulse; begins a run when idle
stop  in  1  pulse; request end of run after the current frame
num_frames  in  CNT_W  frames per run, 0 = continuous; latched on start
pattern_sel  in  2  pattern selector, latched at each SOF
m_axis_tdata  out  32  {8'h00, R[7:0], G[7:0], B[7:0]}
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  sink ready
m_axis_tlast  out  1  last pixel of line (x == FRAME_W-1)
m_axis_tuser  out  1  first pixel of frame (x == 0, y == 0)
busy  out  1  high from start acceptance until return to IDLE
frame_done  out  1  one-cycle pulse when the last beat of a frame is accepted
frames_sent  out  CNT_W  frames completed in the current run; clears on start

Behaviour:
- Reset (aresetn == 0 at posedge): state IDLE; tvalid, tlast, tuser, busy, frame_done = 0; tdata = 0; frames_sent = 0; x = y = 0; stop_pending = 0. Reset mid-frame drops tvalid on that edge, with no tlast flush.
- All outputs are registered. A beat is accepted when tvalid and tready are both high at a posedge.
- AXIS rule: while tvalid = 1 and tready = 0, tdata, tlast and tuser are held constant. tvalid never falls without an acceptance.
- FSM states: IDLE, ACTIVE, GAP.
- IDLE:
  - start = 1 latches num_frames, clears frames_sent and stop_pending, and sets busy.
  - Next state is ACTIVE. tvalid = 1 with the pixel (0,0) and tuser = 1 on the next cycle, so start-to-first-beat latency is 1 cycle.
  - stop is ignored in IDLE.
- ACTIVE, on each acceptance:
  - x increments. At x = FRAME_W-1, x wraps to 0 and y increments.
  - The next beat is presented on the following cycle, so zero-wait throughput is 1 beat/cycle.
- End of frame (acceptance at x = FRAME_W-1, y = FRAME_H-1):
  - frame_done pulses and frames_sent increments; frames_sent wraps modulo 2^CNT_W.
  - If num_frames != 0 and frames_sent+1 == num_frames, or stop_pending (including a stop arriving in this same cycle): go to IDLE, tvalid = 0, busy = 0.
  - Else if GAP_CYCLES > 0: go to GAP with tvalid = 0 and load the gap counter.
  - Else: stay in ACTIVE and present the next SOF beat on the next cycle, with tvalid staying high.
- GAP: counts GAP_CYCLES cycles with tvalid = 0, then returns to ACTIVE at (0,0). stop in GAP goes to IDLE on the next edge.
- stop in ACTIVE sets stop_pending; the current frame always completes. start while busy is ignored.
- pattern_sel is sampled when each SOF beat is formed and held for the whole frame. The 8-bit frame index is frames_sent[7:0].
- Patterns:
  - 0, colour bars: 8 equal bars of width FRAME_W/8, in order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. The bar index comes from a run counter, not a divider.
  - 1, gradient: R = x[7:0], G = y[7:0], B = frame index.
  - 2, checker: 16x16 tiles, FFFFFF when x[4]^y[4] == 0, else 000000.
  - 3, counter: RGB = (y*FRAME_W + x) mod 2^24, kept as an incrementing register that clears at SOF.
- tdata[31:24] is always 0.

Decomposition:
- Package video_axis_pkg holds:
  - the state enum {IDLE, ACTIVE, GAP};
  - the pattern enum (BARS = 0, GRAD = 1, CHECK = 2, COUNT = 3);
  - the 8 bar colour constants;
  - the tdata field offsets (R 23:16, G 15:8, B 7:0).
- One sub-module, axis_pattern_pixel: purely combinational. It maps (pattern, x, y, bar_idx, pix_cnt, frame_idx) to RGB24.
- The top level owns the FSM, counters and output registers.

Test Plan:
- FRAME_W = 8, FRAME_H = 4, GAP = 3, tready = 1; start, num_frames = 2, pattern 3.
  - Required: 64 beats; tdata 0x000000..0x00001F per frame.
  - tuser only on beats 0 and 32; tlast on beats 7, 15, 23, …; exactly 3 idle cycles between frames.
  - frame_done pulses twice; frames_sent = 2; busy falls after beat 63.
- Same setup with tready toggling pseudo-randomly (~50%).
  - Required: identical accepted sequence to the previous test.
  - Assertion: tdata, tuser and tlast stable while tvalid & !tready; tvalid never falls without acceptance.
- Default 640x480, pattern 0, tready = 1.
  - Required: line 0 pixels 0..79 = 0xFFFFFF, 80..159 = 0xFFFF00, …, 560..639 = 0x000000; 307200 beats per frame.
- num_frames = 0, GAP = 0, pattern 1.
  - Required: back-to-back frames with tvalid continuously high; B increments 0, 1, 2 at each SOF.
  - stop pulsed mid-frame 3: frame 3 completes, then IDLE; frames_sent = 4.
- aresetn low during beat 10 with tready = 0.
  - Required: all outputs 0 on that edge.
  - A new start produces tuser = 1 at pixel (0,0) one cycle later; start pulsed while busy has no effect.
